// File: rtl/id_ex_stage.sv
// Decode/issue stage: decodes one RV32I instruction per cycle into ALU operands and
// control, and holds the result in a valid/ready register for the EXE stage.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [4:0]       alu_ctrl,
  output logic [4:0]       rd,
  output logic             reg_we,
  output logic             is_branch,
  output logic [2:0]       br_funct3,
  output logic [XLEN-1:0]  st_data,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;
  logic            accept;

  logic [XLEN-1:0] d_a, d_b, d_st;
  alu_op_e         d_ctrl;
  logic            d_we, d_mrd, d_mwr, d_br, d_ill;
  logic [2:0]      d_bf3;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign shamt = XLEN'(in_instr[24:20]);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    d_a    = '0;
    d_b    = '0;
    d_st   = '0;
    d_ctrl = ALU_ADD;
    d_we   = 1'b0;
    d_mrd  = 1'b0;
    d_mwr  = 1'b0;
    d_br   = 1'b0;
    d_bf3  = 3'b000;
    d_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_a  = rs1_data;
        d_b  = rs2_data;
        d_we = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0100000) d_ctrl = ALU_SUB;
            else d_ill = (funct7 != 7'b0000000);
          end
          3'b001: begin d_ctrl = ALU_SLL;  d_ill = (funct7 != 7'b0000000); end
          3'b010: begin d_ctrl = ALU_SLT;  d_ill = (funct7 != 7'b0000000); end
          3'b011: begin d_ctrl = ALU_SLTU; d_ill = (funct7 != 7'b0000000); end
          3'b100: begin d_ctrl = ALU_XOR;  d_ill = (funct7 != 7'b0000000); end
          3'b101: begin
            if (funct7 == 7'b0100000) d_ctrl = ALU_SRA;
            else begin
              d_ctrl = ALU_SRL;
              d_ill  = (funct7 != 7'b0000000);
            end
          end
          3'b110: begin d_ctrl = ALU_OR;  d_ill = (funct7 != 7'b0000000); end
          default: begin d_ctrl = ALU_AND; d_ill = (funct7 != 7'b0000000); end
        endcase
      end
      OPC_OP_IMM: begin
        d_a  = rs1_data;
        d_b  = imm_i;
        d_we = 1'b1;
        case (funct3)
          3'b000: d_ctrl = ALU_ADD;
          3'b001: begin
            d_ctrl = ALU_SLL;
            d_b    = shamt;
            d_ill  = (funct7 != 7'b0000000);
          end
          3'b010: d_ctrl = ALU_SLT;
          3'b011: d_ctrl = ALU_SLTU;
          3'b100: d_ctrl = ALU_XOR;
          3'b101: begin
            d_b = shamt;
            if (funct7 == 7'b0100000) d_ctrl = ALU_SRA;
            else begin
              d_ctrl = ALU_SRL;
              d_ill  = (funct7 != 7'b0000000);
            end
          end
          3'b110: d_ctrl = ALU_OR;
          default: d_ctrl = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        d_b  = imm_u;
        d_we = 1'b1;
      end
      OPC_AUIPC: begin
        d_a  = in_pc;
        d_b  = imm_u;
        d_we = 1'b1;
      end
      OPC_LOAD: begin
        d_a   = rs1_data;
        d_b   = imm_i;
        d_we  = 1'b1;
        d_mrd = 1'b1;
      end
      OPC_STORE: begin
        d_a   = rs1_data;
        d_b   = imm_s;
        d_mwr = 1'b1;
        d_st  = rs2_data;
      end
      OPC_BRANCH: begin
        d_a    = rs1_data;
        d_b    = rs2_data;
        d_ctrl = ALU_SUB;
        d_br   = 1'b1;
        d_bf3  = funct3;
        d_ill  = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JAL, OPC_JALR: begin
        d_a  = in_pc;
        d_b  = XLEN'(4);
        d_we = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase

    // An illegal op travels down the pipe as an inert ADD 0+0 with no side effects.
    if (d_ill) begin
      d_a    = '0;
      d_b    = '0;
      d_st   = '0;
      d_ctrl = ALU_ADD;
      d_we   = 1'b0;
      d_mrd  = 1'b0;
      d_mwr  = 1'b0;
      d_br   = 1'b0;
      d_bf3  = 3'b000;
    end
    if (in_instr[11:7] == 5'd0) d_we = 1'b0;
  end

  // Flush beats load and hold; a flushed op never counts as issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= 5'd0;
      rd        <= 5'd0;
      reg_we    <= 1'b0;
      is_branch <= 1'b0;
      br_funct3 <= 3'b000;
      st_data   <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      illegal   <= 1'b0;
      issue_cnt <= '0;
    end else begin
      if (out_valid && out_ready && !flush) issue_cnt <= issue_cnt + CNT_W'(1);
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        alu_a     <= d_a;
        alu_b     <= d_b;
        alu_ctrl  <= d_ctrl;
        rd        <= in_instr[11:7];
        reg_we    <= d_we;
        is_branch <= d_br;
        br_funct3 <= d_bf3;
        st_data   <= d_st;
        mem_rd    <= d_mrd;
        mem_wr    <= d_mwr;
        illegal   <= d_ill;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected ops are queued when driven and
// compared when they appear on the registered outputs.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic        ill;
    logic [4:0]  ctrl;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic [2:0]  bf3;
    logic        mrd;
    logic        mwr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc, rs1_data, rs2_data;
  logic [4:0]       rs1_addr, rs2_addr;
  logic [XLEN-1:0]  alu_a, alu_b, st_data;
  logic [4:0]       alu_ctrl, rd;
  logic             reg_we, is_branch, mem_rd, mem_wr, illegal;
  logic [2:0]       br_funct3;
  logic [CNT_W-1:0] issue_cnt;

  exp_t             obs;
  exp_t             sb[$];
  exp_t             exp_op;
  logic [CNT_W-1:0] exp_cnt;
  int               n_cmp = 0;
  int               n_err = 0;

  localparam logic [31:0] R1 = 32'hF000_0000;
  localparam logic [31:0] R2 = 32'h9000_0000;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .rd(rd),
    .reg_we(reg_we), .is_branch(is_branch), .br_funct3(br_funct3), .st_data(st_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .illegal(illegal), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {illegal, alu_ctrl, rd, reg_we, is_branch, br_funct3, mem_rd, mem_wr,
                alu_a, alu_b, st_data};

  function automatic exp_t ex(input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] ctrl, input logic [4:0] rdi,
                              input logic we, input logic ill, input logic br,
                              input logic [2:0] bf3, input logic mrd, input logic mwr,
                              input logic [31:0] st);
    exp_t e;
    e.a = a; e.b = b; e.ctrl = ctrl; e.rd = rdi; e.we = we; e.ill = ill;
    e.br = br; e.bf3 = bf3; e.mrd = mrd; e.mwr = mwr; e.st = st;
    return e;
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, issue_cnt, in_ready} !== {1'b0, 4'h0, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL reset_ctrl: got v/cnt/rdy %b/%h/%b expected 0/0/1",
               out_valid, issue_cnt, in_ready);
    end
    n_cmp++;
    if (obs !== exp_t'(0)) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
    rst_n   = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_alu_ops();
    logic [31:0] ins[15];
    logic [31:0] pcs[15];
    exp_t        ev[15];
    int          n = 15;
    ins[0]  = 32'h002081B3; pcs[0]  = 32'h0;   ev[0]  = ex(R1, R2, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    ins[1]  = 32'h402081B3; pcs[1]  = 32'h0;   ev[1]  = ex(R1, R2, 1, 3, 1, 0, 0, 0, 0, 0, 0);
    ins[2]  = 32'h40435293; pcs[2]  = 32'h0;   ev[2]  = ex(R1, 32'h4, 7, 5, 1, 0, 0, 0, 0, 0, 0);
    ins[3]  = 32'h123450B7; pcs[3]  = 32'h0;   ev[3]  = ex(0, 32'h12345000, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    ins[4]  = 32'h00001117; pcs[4]  = 32'h100; ev[4]  = ex(32'h100, 32'h1000, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    ins[5]  = 32'h00208463; pcs[5]  = 32'h0;   ev[5]  = ex(R1, R2, 1, 8, 0, 0, 1, 0, 0, 0, 0);
    ins[6]  = 32'h0020A223; pcs[6]  = 32'h0;   ev[6]  = ex(R1, 32'h4, 0, 4, 0, 0, 0, 0, 0, 1, R2);
    ins[7]  = 32'hFFC0A283; pcs[7]  = 32'h0;   ev[7]  = ex(R1, 32'hFFFFFFFC, 0, 5, 1, 0, 0, 0, 1, 0, 0);
    ins[8]  = 32'h00508013; pcs[8]  = 32'h0;   ev[8]  = ex(R1, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ins[9]  = 32'hFFFFFFFF; pcs[9]  = 32'h0;   ev[9]  = ex(0, 0, 0, 5'h1F, 0, 1, 0, 0, 0, 0, 0);
    ins[10] = 32'h4020C1B3; pcs[10] = 32'h0;   ev[10] = ex(0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0);
    ins[11] = 32'h0020B1B3; pcs[11] = 32'h0;   ev[11] = ex(R1, R2, 9, 3, 1, 0, 0, 0, 0, 0, 0);
    ins[12] = 32'h008000EF; pcs[12] = 32'h200; ev[12] = ex(32'h200, 32'h4, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    ins[13] = 32'h0020A463; pcs[13] = 32'h0;   ev[13] = ex(0, 0, 0, 8, 0, 1, 0, 0, 0, 0, 0);
    ins[14] = 32'hFFF0A113; pcs[14] = 32'h0;   ev[14] = ex(R1, 32'hFFFFFFFF, 8, 2, 1, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_op = sb.pop_front();
        n_cmp++;
        if ({out_valid, obs} !== {1'b1, exp_op}) begin
          n_err++;
          $display("[TB] FAIL op%0d: got v=%b %h expected v=1 %h", i - 1, out_valid, obs, exp_op);
        end
      end
      if (i < n) begin
        drive(ins[i], pcs[i], R1, R2);
        sb.push_back(ev[i]);
        if (i == 0) begin
          #1;
          n_cmp++;
          if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin
            n_err++;
            $display("[TB] FAIL rs_addr: got %0d/%0d expected 1/2", rs1_addr, rs2_addr);
          end
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    exp_cnt = exp_cnt + CNT_W'(n);
    n_cmp++;
    if ({out_valid, issue_cnt} !== {1'b0, exp_cnt}) begin
      n_err++;
      $display("[TB] FAIL alu_drain: got v=%b cnt=%h expected v=0 cnt=%h", out_valid, issue_cnt, exp_cnt);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h002081B3, 0, 32'h11111111, 32'h22222222);
    sb.push_back(ex(32'h11111111, 32'h22222222, 0, 3, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(32'h402081B3, 0, 32'h33333333, 32'h44444444);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_cmp++;
      if ({out_valid, in_ready, obs} !== {1'b1, 1'b0, sb[0]}) begin
        n_err++;
        $display("[TB] FAIL hold%0d: got v=%b rdy=%b %h expected v=1 rdy=0 %h",
                 c, out_valid, in_ready, obs, sb[0]);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL release_ready: got %b expected 1", in_ready);
    end
    sb.push_back(ex(32'h33333333, 32'h44444444, 1, 3, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    exp_op = sb.pop_front();
    exp_op = sb.pop_front();
    n_cmp++;
    if ({out_valid, obs} !== {1'b1, exp_op}) begin
      n_err++;
      $display("[TB] FAIL after_hold: got v=%b %h expected v=1 %h", out_valid, obs, exp_op);
    end
    in_valid = 1'b0;
    @(negedge clk);
    exp_cnt = exp_cnt + CNT_W'(2);
    n_cmp++;
    if ({out_valid, issue_cnt} !== {1'b0, exp_cnt}) begin
      n_err++;
      $display("[TB] FAIL hold_drain: got v=%b cnt=%h expected v=0 cnt=%h", out_valid, issue_cnt, exp_cnt);
    end
  endtask

  task automatic test_flush();
    for (int rdy = 0; rdy < 2; rdy++) begin
      @(negedge clk);
      out_ready = 1'b0;
      drive(32'h00508093, 0, 32'h55550000, 0);
      sb.push_back(ex(32'h55550000, 32'h5, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      exp_op = sb.pop_front();
      n_cmp++;
      if ({out_valid, obs} !== {1'b1, exp_op}) begin
        n_err++;
        $display("[TB] FAIL pre_flush%0d: got v=%b %h expected v=1 %h", rdy, out_valid, obs, exp_op);
      end
      drive(32'h402081B3, 0, R1, R2);
      flush     = 1'b1;
      out_ready = (rdy == 1);
      @(negedge clk);
      n_cmp++;
      if ({out_valid, issue_cnt} !== {1'b0, exp_cnt}) begin
        n_err++;
        $display("[TB] FAIL flush%0d: got v=%b cnt=%h expected v=0 cnt=%h", rdy, out_valid, issue_cnt, exp_cnt);
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL flush_idle%0d: got v=%b expected v=0", rdy, out_valid);
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    out_ready = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      n = (ph == 0) ? int'(4'hF - exp_cnt) : 1;
      for (int i = 0; i <= n; i++) begin
        @(negedge clk);
        if (i > 0) begin
          exp_op = sb.pop_front();
          n_cmp++;
          if ({out_valid, obs} !== {1'b1, exp_op}) begin
            n_err++;
            $display("[TB] FAIL wrap_op%0d_%0d: got v=%b %h expected %h", ph, i - 1, out_valid, obs, exp_op);
          end
        end
        if (i < n) begin
          drive(32'h002081B3, 0, 32'(i + 7), 0);
          sb.push_back(ex(32'(i + 7), 0, 0, 3, 1, 0, 0, 0, 0, 0, 0));
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      exp_cnt = exp_cnt + CNT_W'(n);
      n_cmp++;
      if (issue_cnt !== ((ph == 0) ? 4'hF : 4'h0)) begin
        n_err++;
        $display("[TB] FAIL wrap%0d: got cnt=%h expected %h", ph, issue_cnt, (ph == 0) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h002081B3, 0, R1, R2);
    sb.push_back(ex(R1, R2, 0, 3, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    exp_op = sb.pop_front();
    n_cmp++;
    if ({out_valid, obs} !== {1'b1, exp_op}) begin
      n_err++;
      $display("[TB] FAIL pre_rst: got v=%b %h expected v=1 %h", out_valid, obs, exp_op);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, issue_cnt, obs} !== {1'b0, 4'h0, exp_t'(0)}) begin
      n_err++;
      $display("[TB] FAIL mid_rst: got v=%b cnt=%h %h expected all 0", out_valid, issue_cnt, obs);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    exp_cnt  = '0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL no_replay: got v=%b expected 0", out_valid);
    end
    out_ready = 1'b1;
    drive(32'h0020B1B3, 0, 32'h1, 32'h2);
    sb.push_back(ex(32'h1, 32'h2, 9, 3, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    exp_op   = sb.pop_front();
    n_cmp++;
    if ({out_valid, obs} !== {1'b1, exp_op}) begin
      n_err++;
      $display("[TB] FAIL post_rst: got v=%b %h expected v=1 %h", out_valid, obs, exp_op);
    end
    @(negedge clk);
    exp_cnt = exp_cnt + CNT_W'(1);
    n_cmp++;
    if ({out_valid, issue_cnt} !== {1'b0, exp_cnt}) begin
      n_err++;
      $display("[TB] FAIL post_rst_cnt: got v=%b cnt=%h expected v=0 cnt=%h", out_valid, issue_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_hold();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
